gf180mcu_fd_sc_mcu7t5v0__aoi221_bist: RTL and testbench

//  Stimulus driver and response checker for one aoi221 cell instance.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__aoi221_bist.sv | 144 ++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__aoi221_bist.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi221_bist.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__aoi221_bist
// Brief    : Exhaustive stimulus driver and response checker for one aoi221
//            cell. Sweeps all 32 input vectors (binary order on even passes,
//            Gray order on odd passes), compares ZN against the golden
//            ~((A1&A2)|(B1&B2)|C) and reports error count / first failure.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__aoi221_bist #(
   parameter int SETTLE   = 2,
   parameter int N_PASSES = 2,
   parameter int ERR_W    = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   input  logic             ZN,
   output logic             A1,
   output logic             A2,
   output logic             B1,
   output logic             B2,
   output logic             C,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [4:0]       FAIL_VEC
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

   localparam logic [1:0]       c_idle       = 2'd0;
   localparam logic [1:0]       c_run        = 2'd1;
   localparam logic [1:0]       c_done       = 2'd2;
   localparam logic [SW-1:0]    c_settle_max = SW'(SETTLE);
   localparam logic [PW-1:0]    c_last_pass  = PW'(N_PASSES - 1);
   localparam logic [ERR_W-1:0] c_err_sat    = {ERR_W{1'b1}};

   logic [1:0]       state_q,  state_d;
   logic [4:0]       idx_q,    idx_d;
   logic [PW-1:0]    pass_q,   pass_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic [ERR_W-1:0] err_q,    err_d;
   logic [4:0]       fvec_q,   fvec_d;
   logic [4:0]       stim_q,   stim_d;

   logic             w_sample;
   logic             w_last;
   logic             w_exp;
   logic             w_mis;
   logic [4:0]       w_idx_nx;
   logic [PW-1:0]    w_pass_nx;
   logic [4:0]       w_vec_nx;

   // Sample strobe, end-of-run detect, golden response and next sweep vector
   always_comb begin
      w_sample  = (settle_q == c_settle_max);
      w_last    = (idx_q == 5'd31) && (pass_q == c_last_pass);
      w_exp     = ~((stim_q[4] & stim_q[3]) | (stim_q[2] & stim_q[1]) | stim_q[0]);
      // Case inequality: an X or Z on the cell output must count as a failure
      w_mis     = (ZN !== w_exp);
      w_idx_nx  = idx_q + 5'd1;
      w_pass_nx = (idx_q == 5'd31) ? pass_q + PW'(1) : pass_q;
      w_vec_nx  = w_pass_nx[0] ? (w_idx_nx ^ (w_idx_nx >> 1)) : w_idx_nx;
   end

   // State register plus all datapath flops, synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RN) begin
         state_q  <= c_idle;
         idx_q    <= '0;
         pass_q   <= '0;
         settle_q <= '0;
         err_q    <= '0;
         fvec_q   <= '0;
         stim_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         pass_q   <= pass_d;
         settle_q <= settle_d;
         err_q    <= err_d;
         fvec_q   <= fvec_d;
         stim_q   <= stim_d;
      end
   end

   // Next-state logic: START only honoured outside RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_idle:  if (START) state_d = c_run;
         c_run:   if (w_sample && w_last) state_d = c_done;
         c_done:  if (START) state_d = c_run;
         default: state_d = c_idle;
      endcase
   end

   // Datapath: run initialisation, settle counting, sampling and sweep advance
   always_comb begin
      idx_d    = idx_q;
      pass_d   = pass_q;
      settle_d = settle_q;
      err_d    = err_q;
      fvec_d   = fvec_q;
      stim_d   = stim_q;
      if ((state_q != c_run) && START) begin
         idx_d    = '0;
         pass_d   = '0;
         settle_d = SW'(1);
         err_d    = '0;
         fvec_d   = '0;
         stim_d   = 5'd0;
      end else if (state_q == c_run) begin
         if (w_sample) begin
            if (w_mis) begin
               if (err_q != c_err_sat) err_d = err_q + ERR_W'(1);
               // Error count only ever rises, so zero means no earlier failure
               if (err_q == '0) fvec_d = stim_q;
            end
            settle_d = SW'(1);
            idx_d    = w_idx_nx;
            pass_d   = w_pass_nx;
            stim_d   = w_last ? 5'd0 : w_vec_nx;
         end else begin
            settle_d = settle_q + SW'(1);
         end
      end
   end

   // Output decode from state and registered datapath
   always_comb begin
      BUSY     = (state_q == c_run);
      DONE     = (state_q == c_done);
      PASS     = (state_q == c_done) && (err_q == '0);
      {A1, A2, B1, B2, C} = stim_q;
      ERR_CNT  = err_q;
      FAIL_VEC = fvec_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__aoi221_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu7t5v0__aoi221_bist
// Brief    : Self-checking bench for the aoi221 BIST. Two instances (8-bit
//            and 4-bit error counter) share control; the cell under test is
//            the golden aoi221 with a per-vector flip mask injecting faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu7t5v0__aoi221_bist;

   localparam int SETTLE  = 2;
   localparam int NP      = 2;
   localparam int RUN_LEN = NP * 32 * SETTLE;

   logic        clk = 1'b0;
   logic        rn;
   logic        start;
   logic [31:0] flip_mask;

   wire  [4:0]  vec8, vec4;
   wire         busy8, done8, pass8, busy4, done4, pass4;
   wire  [7:0]  err8;
   wire  [3:0]  err4;
   wire  [4:0]  fv8, fv4;
   wire         zn8, zn4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic golden(input logic [4:0] v);
      return ~((v[4] & v[3]) | (v[2] & v[1]) | v[0]);
   endfunction

   // Cell under test: golden response with selected vectors inverted
   assign zn8 = golden(vec8) ^ flip_mask[vec8];
   assign zn4 = golden(vec4) ^ flip_mask[vec4];

   gf180mcu_fd_sc_mcu7t5v0__aoi221_bist #(.SETTLE(SETTLE), .N_PASSES(NP), .ERR_W(8)) dut (
      .CLK(clk), .RN(rn), .START(start), .ZN(zn8),
      .A1(vec8[4]), .A2(vec8[3]), .B1(vec8[2]), .B2(vec8[1]), .C(vec8[0]),
      .BUSY(busy8), .DONE(done8), .PASS(pass8), .ERR_CNT(err8), .FAIL_VEC(fv8)
   );

   gf180mcu_fd_sc_mcu7t5v0__aoi221_bist #(.SETTLE(SETTLE), .N_PASSES(NP), .ERR_W(4)) dut4 (
      .CLK(clk), .RN(rn), .START(start), .ZN(zn4),
      .A1(vec4[4]), .A2(vec4[3]), .B1(vec4[2]), .B2(vec4[1]), .C(vec4[0]),
      .BUSY(busy4), .DONE(done4), .PASS(pass4), .ERR_CNT(err4), .FAIL_VEC(fv4)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] sweep_vec(input int j);
      int p = j / 32;
      int i = j % 32;
      return (p % 2 == 1) ? 5'(i ^ (i >> 1)) : 5'(i);
   endfunction

   // Reference: walk every sample of the run in order, count flipped vectors
   task automatic model(input logic [31:0] m, output int cnt, output logic [4:0] first);
      cnt   = 0;
      first = 5'd0;
      for (int j = 0; j < NP * 32; j++) begin
         logic [4:0] v = sweep_vec(j);
         if (m[v]) begin
            if (cnt == 0) first = v;
            cnt++;
         end
      end
   endtask

   task automatic run_and_check(input string name, input logic [31:0] m, input bit noise);
      int         busy_n  = 0;
      int         seq_bad = 0;
      int         cnt;
      logic [4:0] first;
      flip_mask = m;
      model(m, cnt, first);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk_eq({name, "_done_drop"}, {31'd0, done8}, 32'd0);
      while (busy8 && busy_n < 4 * RUN_LEN) begin
         if (vec8 !== sweep_vec(busy_n / SETTLE) || vec4 !== sweep_vec(busy_n / SETTLE))
            seq_bad++;
         busy_n++;
         // Stray STARTs while running, always including the last-sample cycle
         start = noise && (($urandom_range(0, 7) == 0) || busy_n == RUN_LEN);
         @(negedge clk);
      end
      start = 1'b0;
      chk_eq({name, "_busy_len"}, busy_n, RUN_LEN);
      chk_eq({name, "_seq_err"},  seq_bad, 0);
      chk_eq({name, "_done"},     {31'd0, done8}, 32'd1);
      chk_eq({name, "_pass"},     {31'd0, pass8}, (cnt == 0) ? 32'd1 : 32'd0);
      chk_eq({name, "_err8"},     err8, (cnt > 255) ? 255 : cnt);
      chk_eq({name, "_fvec8"},    fv8, first);
      chk_eq({name, "_stim_idle"}, vec8, 0);
      chk_eq({name, "_err4"},     err4, (cnt > 15) ? 15 : cnt);
      chk_eq({name, "_fvec4"},    fv4, first);
      chk_eq({name, "_pass4"},    {31'd0, pass4}, (cnt == 0) ? 32'd1 : 32'd0);
      repeat (3) @(negedge clk);
      chk_eq({name, "_done_hold"}, {31'd0, done8, busy8}, 32'd2);
      chk_eq({name, "_err_hold"},  err8, (cnt > 255) ? 255 : cnt);
   endtask

   initial begin
      logic [31:0] m_s0, m_s1, m_igc;
      rn        = 1'b0;
      start     = 1'b0;
      flip_mask = '0;
      for (int v = 0; v < 32; v++) begin
         logic [4:0] vv = 5'(v);
         logic       no_c = ~((vv[4] & vv[3]) | (vv[2] & vv[1]));
         m_s0[v]  = golden(vv);
         m_s1[v]  = ~golden(vv);
         m_igc[v] = golden(vv) ^ no_c;
      end

      repeat (2) @(negedge clk);
      chk_eq("rst_outs", {vec8, busy8, done8, pass8, err8, fv8}, 32'd0);
      chk_eq("rst_outs4", {vec4, busy4, done4, pass4, err4, fv4}, 32'd0);
      rn = 1'b1;
      @(negedge clk);
      chk_eq("idle_no_start", {31'd0, busy8 | done8}, 32'd0);

      run_and_check("golden",  32'd0, 1'b1);
      run_and_check("stuck0",  m_s0,  1'b0);
      run_and_check("ignore_c", m_igc, 1'b1);
      run_and_check("stuck1",  m_s1,  1'b0);
      for (int r = 0; r < 6; r++)
         run_and_check($sformatf("rand%0d", r), $urandom & $urandom & $urandom, 1'($urandom_range(0, 1)));

      // Abort a run during vector 10 of pass 0
      flip_mask = 32'h0000_0006;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (20) @(negedge clk);
      chk_eq("abort_vec", vec8, 10);
      chk_eq("abort_err_pre", err8, 2);
      rn = 1'b0;
      @(negedge clk) rn = 1'b1;
      chk_eq("abort_outs", {vec8, busy8, done8, pass8, err8, fv8}, 32'd0);
      chk_eq("abort_outs4", {vec4, busy4, done4, pass4, err4, fv4}, 32'd0);
      repeat (2) @(negedge clk);
      chk_eq("abort_idle", {31'd0, busy8 | done8}, 32'd0);
      run_and_check("rerun", 32'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
